stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core_pkg.sv | 44 ++++
 rtl/stopwatch_core_if.sv | 22 ++
 rtl/stopwatch_core_cs_tick_gen.sv | 26 ++
 rtl/stopwatch_core.sv | 113 +++++++++++
 tb/tb_stopwatch_core.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_core_pkg.sv
// rtl/stopwatch_core_pkg.sv - shared states, BCD widths, limits and time constants for stopwatch_core
package stopwatch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int DIGIT_W    = 4;
    localparam int TIME_W     = 24;
    localparam int NUM_DIGITS = TIME_W / DIGIT_W;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS  = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_UNITS = 4'd9;

    localparam logic [TIME_W-1:0] TIME_ZERO = 24'h000000;
    localparam logic [TIME_W-1:0] TIME_MAX  = 24'h595999;

    // Nibble 0 is hundredths; nibbles 3 (sec10) and 5 (min10) wrap at 5.
    function automatic logic [TIME_W-1:0] bcd_time_inc(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0]  r;
        logic               carry;
        logic [DIGIT_W-1:0] lim;
        logic [DIGIT_W-1:0] d;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lim = (i == 3 || i == 5) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS;
            d   = r[i*DIGIT_W +: DIGIT_W];
            if (carry) begin
                if (d >= lim) begin
                    r[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    r[i*DIGIT_W +: DIGIT_W] = d + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// rtl/stopwatch_core_if.sv - control pulses and display outputs of stopwatch_core
interface stopwatch_core_if;
    import stopwatch_core_pkg::*;

    logic              start_stop;
    logic              lap;
    logic              clear;
    logic [TIME_W-1:0] disp_time;
    logic              running;
    logic              lap_held;
    logic              overflow;

    modport master (
        output start_stop, lap, clear,
        input  disp_time, running, lap_held, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
        output disp_time, running, lap_held, overflow
    );
endinterface

// File: rtl/stopwatch_core_cs_tick_gen.sv
// rtl/stopwatch_core_cs_tick_gen.sv - hundredth-second prescaler emitting a one-cycle tick
module cs_tick_gen #(
    parameter int TICKS_PER_CS = 500000
) (
    input  logic mclk,
    input  logic rst,
    input  logic en,
    input  logic zero,
    output logic tick
);
    localparam int CW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_CS - 1);

    logic [CW-1:0] cnt;

    // Disabled counting holds the phase so a paused run resumes mid-interval.
    always_ff @(posedge mclk) begin
        if (rst || zero) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == TERM);
endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - stopwatch FSM, BCD count and display; LAP split enabled by STOPWATCH_LAP_EN
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int TICKS_PER_CS = 500000
) (
    input  logic             mclk,
    input  logic             rst,
    stopwatch_core_if.slave  sw
);
    sw_state_t         state;
    sw_state_t         state_nxt;
    logic [TIME_W-1:0] count;
    logic              overflow_q;
    logic              cs_tick;
    logic              tick_en;
    logic              tick_zero;
    logic              at_max;
    logic              sat_tick;
    logic              clear_hit;

    assign tick_en   = (state == ST_RUN) || (state == ST_LAP);
    assign tick_zero = (state == ST_IDLE);
    assign at_max    = (count == TIME_MAX);
    assign sat_tick  = cs_tick && at_max;
    assign clear_hit = (state == ST_PAUSE) && sw.clear;

    cs_tick_gen #(
        .TICKS_PER_CS(TICKS_PER_CS)
    ) u_tick (
        .mclk (mclk),
        .rst  (rst),
        .en   (tick_en),
        .zero (tick_zero),
        .tick (cs_tick)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturation forces PAUSE ahead of any pulse arriving in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sw.start_stop) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (sat_tick || sw.start_stop) state_nxt = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                else if (sw.lap)               state_nxt = ST_LAP;
`endif
            end
            ST_PAUSE: begin
                if (sw.clear)                        state_nxt = ST_IDLE;
                else if (sw.start_stop && !overflow_q) state_nxt = ST_RUN;
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (sat_tick || sw.start_stop) state_nxt = ST_PAUSE;
                else if (sw.lap)               state_nxt = ST_RUN;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst || clear_hit) begin
            count      <= TIME_ZERO;
            overflow_q <= 1'b0;
        end else if (cs_tick) begin
            if (at_max) begin
                overflow_q <= 1'b1;
            end else begin
                count <= bcd_time_inc(count);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [TIME_W-1:0] snapshot;

    always_ff @(posedge mclk) begin
        if (rst || clear_hit) begin
            snapshot <= TIME_ZERO;
        end else if (state == ST_RUN && state_nxt == ST_LAP) begin
            snapshot <= count;
        end
    end
`else
    logic lap_unused;
    assign lap_unused = sw.lap;
`endif

    always_comb begin
        sw.running   = tick_en;
        sw.lap_held  = 1'b0;
        sw.disp_time = count;
        sw.overflow  = overflow_q;
`ifdef STOPWATCH_LAP_EN
        if (state == ST_LAP) begin
            sw.lap_held  = 1'b1;
            sw.disp_time = snapshot;
        end
`endif
    end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - randomized and directed self-checking bench for stopwatch_core
module tb_stopwatch_core;
    localparam int T      = 4;
    localparam int MAX_CS = 359999;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;

    stopwatch_core_if sw();

    stopwatch_core #(
        .TICKS_PER_CS(T)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .sw   (sw)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: time kept as whole hundredths, phase as cycles into the hundredth.
    int m_st   = M_IDLE;
    int m_ph   = 0;
    int m_t    = 0;
    int m_snap = 0;
    bit m_ov   = 1'b0;

    bit          chk_en   = 1'b0;
    bit          skip_chk = 1'b0;
    bit          pre_req  = 1'b0;
    int          pre_cs   = 0;
    logic [23:0] pre_bcd  = 24'h0;

    function automatic logic [23:0] to_bcd(input int t);
        int mn, sc, cs;
        mn = t / 6000;
        sc = (t / 100) % 60;
        cs = t % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        return int'(b[23:20]) * 60000 + int'(b[19:16]) * 6000 + int'(b[15:12]) * 1000
             + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge mclk) begin : model
        int t_n, ph_n, snap_n, st_n;
        bit ov_n, tick, sat, active;
        active = (m_st == M_RUN) || (m_st == M_LAP);
        tick   = active && (m_ph == T - 1);
        sat    = tick && (m_t == MAX_CS);
        t_n = m_t; ph_n = m_ph; snap_n = m_snap; st_n = m_st; ov_n = m_ov;
        if (m_st == M_IDLE) ph_n = 0;
        else if (active)    ph_n = (m_ph + 1) % T;
        if (m_st == M_PAUSE && sw.clear) begin
            t_n = 0; ov_n = 1'b0; snap_n = 0; st_n = M_IDLE;
        end else begin
            if (sat)       ov_n = 1'b1;
            else if (tick) t_n = m_t + 1;
            case (m_st)
                M_IDLE:  if (sw.start_stop) st_n = M_RUN;
                M_RUN: begin
                    if (sat || sw.start_stop) st_n = M_PAUSE;
                    else if (LAP_EN && sw.lap) begin
                        st_n = M_LAP; snap_n = m_t;
                    end
                end
                M_LAP: begin
                    if (sat || sw.start_stop) st_n = M_PAUSE;
                    else if (sw.lap)          st_n = M_RUN;
                end
                default: if (sw.start_stop && !m_ov) st_n = M_RUN;
            endcase
        end
        if (pre_req) t_n = pre_cs;
        if (rst) begin
            t_n = 0; ph_n = 0; snap_n = 0; st_n = M_IDLE; ov_n = 1'b0;
        end
        m_t <= t_n; m_ph <= ph_n; m_snap <= snap_n; m_st <= st_n; m_ov <= ov_n;
    end

    always @(negedge mclk) begin
        if (chk_en && !skip_chk) begin
            check("disp_time", sw.disp_time, to_bcd(m_st == M_LAP ? m_snap : m_t));
            check_bit("running", sw.running, m_st == M_RUN || m_st == M_LAP);
            check_bit("lap_held", sw.lap_held, m_st == M_LAP);
            check_bit("overflow", sw.overflow, m_ov);
        end
    end

    task automatic cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse(input bit ss, input bit lp, input bit cl);
        sw.start_stop = ss; sw.lap = lp; sw.clear = cl;
        cycle();
        sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Only valid while paused or idle, where the count register is not updated.
    task automatic preload(input logic [23:0] v);
        pre_bcd  = v;
        pre_cs   = from_bcd(v);
        pre_req  = 1'b1;
        skip_chk = 1'b1;
        force dut.count = pre_bcd;
        cycle();
        release dut.count;
        pre_req  = 1'b0;
        skip_chk = 1'b0;
    endtask

    task automatic resume_from(input logic [23:0] v);
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        preload(v);
        pulse(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int v;
        rst = 1'b1;
        sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
        cycle();
        chk_en = 1'b1;
        check("reset_disp", sw.disp_time, 24'h000000);
        check_bit("reset_running", sw.running, 1'b0);
        check_bit("reset_lap_held", sw.lap_held, 1'b0);
        check_bit("reset_overflow", sw.overflow, 1'b0);
        rst = 1'b0;

        pulse(1'b1, 1'b0, 1'b0);
        repeat (400) cycle();
        check("one_second", sw.disp_time, 24'h000100);
        check_bit("one_second_running", sw.running, 1'b1);

        repeat (412 * T) cycle();
        check("pre_lap", sw.disp_time, 24'h000512);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (40) cycle();
`ifdef STOPWATCH_LAP_EN
        check("lap_hold", sw.disp_time, 24'h000512);
`else
        check("lap_hold", sw.disp_time, 24'h000522);
`endif
        check_bit("lap_running", sw.running, 1'b1);
        check_bit("lap_flag", sw.lap_held, LAP_EN);
        pulse(1'b0, 1'b1, 1'b0);
        check("lap_release", sw.disp_time, 24'h000522);
        check_bit("lap_release_flag", sw.lap_held, 1'b0);

        resume_from(24'h005999);
        repeat (3) cycle();
        check("minute_carry", sw.disp_time, 24'h010000);
        resume_from(24'h095999);
        repeat (3) cycle();
        check("ten_minute_carry", sw.disp_time, 24'h100000);

        resume_from(24'h595999);
        repeat (3) cycle();
        check("saturate_disp", sw.disp_time, 24'h595999);
        check_bit("saturate_overflow", sw.overflow, 1'b1);
        check_bit("saturate_paused", sw.running, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_bit("overflow_start_ignored", sw.running, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check("overflow_clear_disp", sw.disp_time, 24'h000000);
        check_bit("overflow_clear_flag", sw.overflow, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check_bit("idle_restart", sw.running, 1'b1);

        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (8) cycle();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        check("clear_priority_disp", sw.disp_time, 24'h000000);
        check_bit("clear_priority_idle", sw.running, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (7) cycle();
        pulse(1'b0, 1'b0, 1'b1);
        check("run_clear_ignored", sw.disp_time, 24'h000002);
        check_bit("run_clear_running", sw.running, 1'b1);

        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (1234 * T) cycle();
        pulse(1'b0, 1'b1, 1'b0);
        check("lap_at_1234", sw.disp_time, 24'h001234);
        check_bit("lap_at_1234_flag", sw.lap_held, LAP_EN);
        do_reset();
        check("rst_lap_disp", sw.disp_time, 24'h000000);
        check_bit("rst_lap_running", sw.running, 1'b0);
        check_bit("rst_lap_flag", sw.lap_held, 1'b0);
        check_bit("rst_lap_overflow", sw.overflow, 1'b0);
        repeat (20) cycle();
        check("rst_no_carry", sw.disp_time, 24'h000000);

        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: v = 5990 + int'($urandom_range(0, 9));
                1: v = 59990 + int'($urandom_range(0, 9));
                2: v = 359990 + int'($urandom_range(0, 9));
                default: v = int'($urandom_range(0, MAX_CS));
            endcase
            resume_from(to_bcd(v));
            for (int c = 0; c < 1500; c++) begin
                sw.start_stop = ($urandom_range(0, 39) == 0);
                sw.lap        = ($urandom_range(0, 29) == 0);
                sw.clear      = ($urandom_range(0, 29) == 0);
                rst           = ($urandom_range(0, 499) == 0);
                cycle();
                sw.start_stop = 1'b0; sw.lap = 1'b0; sw.clear = 1'b0;
                rst = 1'b0;
            end
        end

        cycle();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
